// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encodings
// and default streak / timeout limits.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MEMARB_IDLE    = 2'd0,
        MEMARB_BUSY_IF = 2'd1,
        MEMARB_BUSY_LS = 2'd2,
        MEMARB_DONE    = 2'd3
    } memarb_state_t;

    localparam int MEMARB_LS_STREAK = 4;
    localparam int MEMARB_TIMEOUT   = 64;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Loadable up-counter with clear, enable and a terminal-count flag, used to
// bound how long a transfer may wait for the memory acknowledge.
module memarb_timeout_ctr #(
    parameter int          W      = 6,
    parameter int unsigned TC_VAL = 63
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    // Clear dominates load, which dominates counting.
    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count + W'(1);
    end

    assign tc = (count == W'(TC_VAL));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and
// load/store traffic, with LS priority, an IF anti-starvation streak limit and an ack timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LS_STREAK = MEMARB_LS_STREAK,
    parameter int TIMEOUT   = MEMARB_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    output logic          if_stall,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_ready,
    output logic          ls_stall,
    output logic          bus_err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack
);

    localparam int SW = $clog2(LS_STREAK + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    memarb_state_t state, next_state;

    logic [SW-1:0] streak;
    logic          owner_ls;
    logic          err_q;
    logic          grant_ls, grant_if, force_if;
    logic          busy, finish, timed_out;
    logic [TW-1:0] tmo_count;
    logic          tmo_tc;
    logic [DW-1:0] done_rdata;

    always_ff @(posedge clk) begin
        if (rst)
            state <= MEMARB_IDLE;
        else
            state <= next_state;
    end

    // IF gets one forced grant once LS has won LS_STREAK times in a row over it.
    always_comb begin
        next_state = state;
        grant_ls   = 1'b0;
        grant_if   = 1'b0;
        force_if   = (streak == SW'(LS_STREAK)) && if_req;
        case (state)
            MEMARB_IDLE: begin
                if (ls_req && !force_if) begin
                    grant_ls   = 1'b1;
                    next_state = MEMARB_BUSY_LS;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    next_state = MEMARB_BUSY_IF;
                end
            end
            MEMARB_BUSY_IF, MEMARB_BUSY_LS: begin
                if (finish)
                    next_state = MEMARB_DONE;
            end
            MEMARB_DONE: next_state = MEMARB_IDLE;
            default:     next_state = MEMARB_IDLE;
        endcase
    end

    assign busy      = (state == MEMARB_BUSY_IF) || (state == MEMARB_BUSY_LS);
    assign timed_out = busy && !m_ack && tmo_tc;
    assign finish    = busy && (m_ack || tmo_tc);
    assign done_rdata = (m_ack && !m_we) ? m_rdata : '0;

    memarb_timeout_ctr #(
        .W      (TW),
        .TC_VAL (TIMEOUT - 1)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == MEMARB_DONE),
        .load     (grant_ls || grant_if),
        .load_val ('0),
        .en       (busy && !m_ack),
        .count    (tmo_count),
        .tc       (tmo_tc)
    );

    // Request latch at grant, streak bookkeeping, and completion capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_addr   <= '0;
            m_we     <= 1'b0;
            m_wdata  <= '0;
            streak   <= '0;
            owner_ls <= 1'b0;
            err_q    <= 1'b0;
            if_rdata <= '0;
            ls_rdata <= '0;
        end else begin
            if (grant_ls) begin
                m_addr   <= ls_addr;
                m_we     <= ls_we;
                m_wdata  <= ls_wdata;
                owner_ls <= 1'b1;
                streak   <= if_req ? streak + SW'(1) : '0;
            end else if (grant_if) begin
                m_addr   <= if_addr;
                m_we     <= 1'b0;
                m_wdata  <= '0;
                owner_ls <= 1'b0;
                streak   <= '0;
            end
            if (finish) begin
                err_q <= timed_out;
                if (state == MEMARB_BUSY_LS)
                    ls_rdata <= done_rdata;
                else
                    if_rdata <= done_rdata;
            end
        end
    end

    assign m_req    = busy;
    assign if_ready = (state == MEMARB_DONE) && !owner_ls;
    assign ls_ready = (state == MEMARB_DONE) && owner_ls;
    assign bus_err  = (state == MEMARB_DONE) && err_q;
    assign if_stall = if_req && !if_ready;
    assign ls_stall = ls_req && !ls_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: load, store, streak
// fairness, timeout, mid-transfer reset and spurious acknowledge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we, m_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, m_rdata;
    logic [31:0] if_rdata, ls_rdata, m_addr, m_wdata;
    logic        if_ready, if_stall, ls_ready, ls_stall, bus_err, m_req, m_we;

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .LS_STREAK(4), .TIMEOUT(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .if_stall (if_stall),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_rdata (ls_rdata),
        .ls_ready (ls_ready),
        .ls_stall (ls_stall),
        .bus_err  (bus_err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic        exp_if;
        logic [31:0] exp_addr;
        int          cnt;

        rst = 1'b1; if_req = 0; ls_req = 0; ls_we = 0; m_ack = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; m_rdata = 0;
        tick(); tick();
        rst = 1'b0;
        check_output("rst_m_req",    32'(m_req),    0);
        check_output("rst_if_ready", 32'(if_ready), 0);
        check_output("rst_ls_ready", 32'(ls_ready), 0);
        check_output("rst_bus_err",  32'(bus_err),  0);
        check_output("rst_m_addr",   m_addr,        0);
        check_output("rst_ls_rdata", ls_rdata,      0);

        // Load with immediate ack
        ls_req = 1; ls_we = 0; ls_addr = 32'h100;
        tick();
        check_output("ld_m_req",    32'(m_req),    1);
        check_output("ld_m_addr",   m_addr,        32'h100);
        check_output("ld_m_we",     32'(m_we),     0);
        check_output("ld_ls_stall", 32'(ls_stall), 1);
        m_ack = 1; m_rdata = 32'hDEADBEEF;
        tick();
        m_ack = 0;
        check_output("ld_ls_ready", 32'(ls_ready), 1);
        check_output("ld_ls_rdata", ls_rdata,      32'hDEADBEEF);
        check_output("ld_m_req_off", 32'(m_req),   0);
        check_output("ld_bus_err",  32'(bus_err),  0);
        check_output("ld_stall_off", 32'(ls_stall), 0);
        ls_req = 0;
        tick();
        check_output("ld_ready_once", 32'(ls_ready), 0);

        // Store acked on its fourth busy cycle
        ls_req = 1; ls_we = 1; ls_addr = 32'h40; ls_wdata = 32'h12345678; m_rdata = 32'hCAFEF00D;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_output("st_m_req",   32'(m_req),    1);
            check_output("st_m_we",    32'(m_we),     1);
            check_output("st_m_wdata", m_wdata,       32'h12345678);
            check_output("st_no_ready", 32'(ls_ready), 0);
            if (k == 3) m_ack = 1;
            tick();
        end
        m_ack = 0;
        check_output("st_ls_ready", 32'(ls_ready), 1);
        check_output("st_ls_rdata", ls_rdata,      0);
        check_output("st_m_req_off", 32'(m_req),   0);
        ls_req = 0; ls_we = 0;
        tick();
        check_output("st_ready_once", 32'(ls_ready), 0);

        // Both requesters held: LS x4, IF, LS x4, IF
        if_req = 1; if_addr = 32'h200; ls_req = 1; ls_addr = 32'h300;
        for (int t = 0; t < 10; t++) begin
            exp_if   = (t == 4) || (t == 9);
            exp_addr = exp_if ? 32'h200 : 32'h300;
            tick();
            check_output("fair_m_addr", m_addr, exp_addr);
            if (t < 4) check_output("fair_if_stall", 32'(if_stall), 1);
            m_ack = 1; m_rdata = 32'(t + 1);
            tick();
            m_ack = 0;
            check_output("fair_if_ready", 32'(if_ready), 32'(exp_if));
            check_output("fair_ls_ready", 32'(ls_ready), 32'(!exp_if));
            if (exp_if) check_output("fair_if_rdata", if_rdata, 32'(t + 1));
            if (t == 9) begin if_req = 0; ls_req = 0; end
            tick();
        end

        // Never acked: timeout after 64 busy cycles
        ls_req = 1; ls_we = 0; ls_addr = 32'h80; m_rdata = 32'hFFFFFFFF;
        tick();
        cnt = 0;
        while (m_req && cnt < 200) begin
            cnt++;
            tick();
        end
        check_output("tmo_busy_cycles", 32'(cnt),     64);
        check_output("tmo_ls_ready",    32'(ls_ready), 1);
        check_output("tmo_bus_err",     32'(bus_err),  1);
        check_output("tmo_ls_rdata",    ls_rdata,      0);
        ls_req = 0;
        tick();
        check_output("tmo_err_once", 32'(bus_err), 0);

        // Reset two cycles into a load, then a normal fetch
        ls_req = 1; ls_addr = 32'h500;
        tick(); tick();
        check_output("rb_m_req", 32'(m_req), 1);
        rst = 1;
        tick();
        check_output("rb_m_req_off", 32'(m_req),    0);
        check_output("rb_no_ready",  32'(ls_ready), 0);
        check_output("rb_no_err",    32'(bus_err),  0);
        rst = 0; ls_req = 0;
        tick();
        check_output("rb_idle_ready", 32'(ls_ready), 0);
        if_req = 1; if_addr = 32'h600;
        tick();
        check_output("rb_if_m_addr", m_addr,     32'h600);
        check_output("rb_if_m_we",   32'(m_we),  0);
        m_ack = 1; m_rdata = 32'h600D;
        tick();
        m_ack = 0; if_req = 0;
        check_output("rb_if_ready", 32'(if_ready), 1);
        check_output("rb_if_rdata", if_rdata,      32'h600D);
        check_output("rb_ls_quiet", 32'(ls_ready), 0);
        tick();

        // Spurious acknowledge while idle
        m_ack = 1;
        tick();
        m_ack = 0;
        check_output("sp_m_req",    32'(m_req),    0);
        check_output("sp_if_ready", 32'(if_ready), 0);
        check_output("sp_ls_ready", 32'(ls_ready), 0);
        tick();
        check_output("sp_m_req2",    32'(m_req),    0);
        check_output("sp_ls_ready2", 32'(ls_ready), 0);
        check_output("sp_if_ready2", 32'(if_ready), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
